// File: rtl/commit_trace_pkg.sv
// Shared types for the commit-trace arbiter: the trace record layout and FSM states.
package commit_trace_pkg;

    localparam int XLEN_DEF = 32;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] nextpc;
        logic [XLEN_DEF-1:0] inst;
    } commit_rec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ct_state_t;

endpackage

// File: rtl/commit_trace_fifo.sv
// In-order FIFO of commit records; the head is shown combinationally and the last
// popped record is held so the output is stable while the FIFO is empty.
module commit_trace_fifo
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_push,
    input  commit_rec_t            i_data,
    input  logic                   i_pop,
    output commit_rec_t            o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    commit_rec_t   r_mem [DEPTH];
    commit_rec_t   r_last;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = o_empty ? r_last : r_mem[r_rptr];

    // Storage carries no reset; it is only read while count is non-zero.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_last  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
                r_last <= r_mem[r_rptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/commit_trace_arbiter.sv
// Round-robin merge of two commit-trace sources into one FIFO-buffered stream, with a
// flush handshake. Optional per-source statistics under `COMMIT_TRACE_STAT_EN.
module commit_trace_arbiter
    import commit_trace_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   s0_valid,
    output logic                   s0_ready,
    input  logic [XLEN-1:0]        s0_pc,
    input  logic [XLEN-1:0]        s0_nextpc,
    input  logic [XLEN-1:0]        s0_inst,
    input  logic                   s1_valid,
    output logic                   s1_ready,
    input  logic [XLEN-1:0]        s1_pc,
    input  logic [XLEN-1:0]        s1_nextpc,
    input  logic [XLEN-1:0]        s1_inst,
    input  logic                   flush_req,
    output logic                   flush_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_nextpc,
    output logic [XLEN-1:0]        out_inst,
    output logic [$clog2(DEPTH):0] occupancy
`ifdef COMMIT_TRACE_STAT_EN
    ,
    output logic [31:0]            stat_s0_cnt,
    output logic [31:0]            stat_s1_cnt,
    output logic [31:0]            stat_full_cyc
`endif
);

    ct_state_t   r_state;
    ct_state_t   w_state_nxt;
    logic        r_last_grant;
    logic        w_base_ready;
    logic        w_grant_s0;
    logic        w_grant_s1;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    commit_rec_t w_push_rec;
    commit_rec_t w_head;

    // r_last_grant: 0 = s0 won last, 1 = s1 won last; reset to 1 so s0 wins the first tie.
    assign w_base_ready = (r_state == RUN) && !w_full;
    assign w_grant_s1   = s1_valid && (!s0_valid || !r_last_grant);
    assign w_grant_s0   = s0_valid && !w_grant_s1;
    assign s0_ready     = w_base_ready && w_grant_s0;
    assign s1_ready     = w_base_ready && w_grant_s1;
    assign w_push       = w_base_ready && (s0_valid || s1_valid);
    assign w_push_rec   = w_grant_s1 ? '{pc: s1_pc, nextpc: s1_nextpc, inst: s1_inst}
                                     : '{pc: s0_pc, nextpc: s0_nextpc, inst: s0_inst};

    assign out_valid  = !w_empty;
    assign w_pop      = out_valid && out_ready;
    assign out_pc     = w_head.pc;
    assign out_nextpc = w_head.nextpc;
    assign out_inst   = w_head.inst;
    assign flush_done = (r_state == DRAIN) && w_empty;

    commit_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_rec),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (occupancy)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_last_grant <= w_grant_s1;
            end
        end
    end

    // A flush request wins over dropping the enable in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (en) w_state_nxt = RUN;
            RUN: begin
                if (flush_req)  w_state_nxt = DRAIN;
                else if (!en)   w_state_nxt = IDLE;
            end
            DRAIN:   if (w_empty) w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef COMMIT_TRACE_STAT_EN
    logic [31:0] r_stat_s0;
    logic [31:0] r_stat_s1;
    logic [31:0] r_stat_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stat_s0   <= '0;
            r_stat_s1   <= '0;
            r_stat_full <= '0;
        end else begin
            if (w_push && w_grant_s0)                r_stat_s0   <= r_stat_s0 + 32'd1;
            if (w_push && w_grant_s1)                r_stat_s1   <= r_stat_s1 + 32'd1;
            if ((s0_valid || s1_valid) && w_full)    r_stat_full <= r_stat_full + 32'd1;
        end
    end

    assign stat_s0_cnt   = r_stat_s0;
    assign stat_s1_cnt   = r_stat_s1;
    assign stat_full_cyc = r_stat_full;
`endif

endmodule

// File: tb/tb_commit_trace_arbiter.sv
// Directed bench for commit_trace_arbiter: a vector table for arbitration and full/empty
// behaviour plus hand-written flush and reset sequences.
module tb_commit_trace_arbiter;

    logic        clock;
    logic        reset;
    logic        en;
    logic        s0_valid, s1_valid;
    logic        s0_ready, s1_ready;
    logic [31:0] s0_pc, s0_nextpc, s0_inst;
    logic [31:0] s1_pc, s1_nextpc, s1_inst;
    logic        flush_req, flush_done;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_nextpc, out_inst;
    logic [2:0]  occupancy;
`ifdef COMMIT_TRACE_STAT_EN
    logic [31:0] stat_s0_cnt, stat_s1_cnt, stat_full_cyc;
`endif

    int checks   = 0;
    int failures = 0;

    commit_trace_arbiter #(.XLEN(32), .DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .s0_valid   (s0_valid),
        .s0_ready   (s0_ready),
        .s0_pc      (s0_pc),
        .s0_nextpc  (s0_nextpc),
        .s0_inst    (s0_inst),
        .s1_valid   (s1_valid),
        .s1_ready   (s1_ready),
        .s1_pc      (s1_pc),
        .s1_nextpc  (s1_nextpc),
        .s1_inst    (s1_inst),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_nextpc (out_nextpc),
        .out_inst   (out_inst),
        .occupancy  (occupancy)
`ifdef COMMIT_TRACE_STAT_EN
        ,
        .stat_s0_cnt   (stat_s0_cnt),
        .stat_s1_cnt   (stat_s1_cnt),
        .stat_full_cyc (stat_full_cyc)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] en, s0v, s0pc, s1v, s1pc, frq, ordy;
        logic [31:0] r0, r1, ov, opc, occ, fd;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Record fields are derived from pc so the bench can predict nextpc/inst.
    task automatic drv(input logic e, input logic v0, input logic [31:0] p0,
                       input logic v1, input logic [31:0] p1,
                       input logic fr, input logic rd);
        en        = e;
        s0_valid  = v0;
        s0_pc     = p0;
        s0_nextpc = p0 + 32'd4;
        s0_inst   = ~p0;
        s1_valid  = v1;
        s1_pc     = p1;
        s1_nextpc = p1 + 32'd4;
        s1_inst   = ~p1;
        flush_req = fr;
        out_ready = rd;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        // en, s0v, s0pc, s1v, s1pc, frq, ordy | r0, r1, ov, opc, occ, fd
        tbl[0]  = '{1, 0, 32'h000, 0, 32'h000, 0, 1,  0, 0, 0, 32'h000, 0, 0};
        tbl[1]  = '{1, 1, 32'h100, 1, 32'h200, 0, 1,  1, 0, 0, 32'h000, 0, 0};
        tbl[2]  = '{1, 1, 32'h104, 1, 32'h200, 0, 1,  0, 1, 1, 32'h100, 1, 0};
        tbl[3]  = '{1, 1, 32'h104, 1, 32'h204, 0, 1,  1, 0, 1, 32'h200, 1, 0};
        tbl[4]  = '{1, 1, 32'h108, 1, 32'h204, 0, 1,  0, 1, 1, 32'h104, 1, 0};
        tbl[5]  = '{1, 0, 32'h000, 0, 32'h000, 0, 1,  0, 0, 1, 32'h204, 1, 0};
        tbl[6]  = '{1, 0, 32'h000, 0, 32'h000, 0, 1,  0, 0, 0, 32'h204, 0, 0};
        tbl[7]  = '{1, 1, 32'h300, 0, 32'h000, 0, 0,  1, 0, 0, 32'h204, 0, 0};
        tbl[8]  = '{1, 1, 32'h304, 0, 32'h000, 0, 0,  1, 0, 1, 32'h300, 1, 0};
        tbl[9]  = '{1, 1, 32'h308, 0, 32'h000, 0, 0,  1, 0, 1, 32'h300, 2, 0};
        tbl[10] = '{1, 1, 32'h30c, 0, 32'h000, 0, 0,  1, 0, 1, 32'h300, 3, 0};
        tbl[11] = '{1, 1, 32'h310, 0, 32'h000, 0, 0,  0, 0, 1, 32'h300, 4, 0};
        tbl[12] = '{1, 1, 32'h310, 0, 32'h000, 0, 0,  0, 0, 1, 32'h300, 4, 0};
        tbl[13] = '{1, 0, 32'h000, 0, 32'h000, 0, 1,  0, 0, 1, 32'h300, 4, 0};
        tbl[14] = '{1, 0, 32'h000, 0, 32'h000, 0, 1,  0, 0, 1, 32'h304, 3, 0};
        tbl[15] = '{1, 0, 32'h000, 0, 32'h000, 0, 1,  0, 0, 1, 32'h308, 2, 0};
        tbl[16] = '{1, 0, 32'h000, 0, 32'h000, 0, 1,  0, 0, 1, 32'h30c, 1, 0};
        tbl[17] = '{1, 0, 32'h000, 0, 32'h000, 0, 1,  0, 0, 0, 32'h30c, 0, 0};

        // Reset state, with inputs that would otherwise push.
        reset = 1'b0;
        drv(1'b1, 1'b1, 32'h10, 1'b1, 32'h20, 1'b1, 1'b1);
        @(negedge clock);
        #1;
        chk("rst.s0_ready", 32'(s0_ready), 0);
        chk("rst.s1_ready", 32'(s1_ready), 0);
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.out_pc", out_pc, 0);
        chk("rst.out_inst", out_inst, 0);
        chk("rst.flush_done", 32'(flush_done), 0);
        chk("rst.occupancy", 32'(occupancy), 0);
        @(negedge clock);
        reset = 1'b1;

        // Single record latency.
        drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        chk("t1.c1.out_valid", 32'(out_valid), 0);
        @(negedge clock);
        drv(1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 1'b1);
        s0_nextpc = 32'h8000_0004;
        s0_inst   = 32'h0000_0013;
        #1;
        chk("t1.c2.s0_ready", 32'(s0_ready), 1);
        chk("t1.c2.s1_ready", 32'(s1_ready), 0);
        chk("t1.c2.out_valid", 32'(out_valid), 0);
        @(negedge clock);
        drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        chk("t1.c3.out_valid", 32'(out_valid), 1);
        chk("t1.c3.out_pc", out_pc, 32'h8000_0000);
        chk("t1.c3.out_nextpc", out_nextpc, 32'h8000_0004);
        chk("t1.c3.out_inst", out_inst, 32'h0000_0013);
        chk("t1.c3.occupancy", 32'(occupancy), 1);
        @(negedge clock);
        #1;
        chk("t1.c4.occupancy", 32'(occupancy), 0);
        chk("t1.c4.out_valid", 32'(out_valid), 0);
        chk("t1.c4.out_pc_hold", out_pc, 32'h8000_0000);
        @(negedge clock);

        // Round-robin and full/empty table, from a fresh reset.
        pulse_reset();
        for (int i = 0; i < 18; i++) begin
            drv(tbl[i].en[0], tbl[i].s0v[0], tbl[i].s0pc, tbl[i].s1v[0], tbl[i].s1pc,
                tbl[i].frq[0], tbl[i].ordy[0]);
            #1;
            chk($sformatf("v%0d.s0_ready", i), 32'(s0_ready), tbl[i].r0);
            chk($sformatf("v%0d.s1_ready", i), 32'(s1_ready), tbl[i].r1);
            chk($sformatf("v%0d.out_valid", i), 32'(out_valid), tbl[i].ov);
            chk($sformatf("v%0d.out_pc", i), out_pc, tbl[i].opc);
            chk($sformatf("v%0d.occupancy", i), 32'(occupancy), tbl[i].occ);
            chk($sformatf("v%0d.flush_done", i), 32'(flush_done), tbl[i].fd);
            if (tbl[i].ov[0]) begin
                chk($sformatf("v%0d.out_nextpc", i), out_nextpc, tbl[i].opc + 32'd4);
                chk($sformatf("v%0d.out_inst", i), out_inst, ~tbl[i].opc);
            end
            @(negedge clock);
        end

        // Flush: third record enters in the flush cycle, then s1 is held off until drained.
        drv(1'b1, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0, 1'b0);
        #1;
        chk("t4.a.s1_ready", 32'(s1_ready), 1);
        @(negedge clock);
        drv(1'b1, 1'b0, 32'h0, 1'b1, 32'h504, 1'b0, 1'b0);
        #1;
        chk("t4.b.s1_ready", 32'(s1_ready), 1);
        chk("t4.b.occupancy", 32'(occupancy), 1);
        @(negedge clock);
        drv(1'b1, 1'b0, 32'h0, 1'b1, 32'h508, 1'b1, 1'b0);
        #1;
        chk("t4.c.s1_ready", 32'(s1_ready), 1);
        chk("t4.c.occupancy", 32'(occupancy), 2);
        @(negedge clock);
        drv(1'b1, 1'b0, 32'h0, 1'b1, 32'h50c, 1'b0, 1'b0);
        #1;
        chk("t4.d.s1_ready", 32'(s1_ready), 0);
        chk("t4.d.occupancy", 32'(occupancy), 3);
        chk("t4.d.flush_done", 32'(flush_done), 0);
        @(negedge clock);
        drv(1'b1, 1'b0, 32'h0, 1'b1, 32'h50c, 1'b1, 1'b0);
        #1;
        chk("t4.e.s1_ready", 32'(s1_ready), 0);
        chk("t4.e.flush_done", 32'(flush_done), 0);
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            drv(1'b1, 1'b0, 32'h0, 1'b1, 32'h50c, 1'b0, 1'b1);
            #1;
            chk($sformatf("t4.pop%0d.out_pc", k), out_pc, 32'h500 + 32'(4 * k));
            chk($sformatf("t4.pop%0d.occupancy", k), 32'(occupancy), 32'(3 - k));
            chk($sformatf("t4.pop%0d.s1_ready", k), 32'(s1_ready), 0);
            chk($sformatf("t4.pop%0d.flush_done", k), 32'(flush_done), 0);
            @(negedge clock);
        end
        #1;
        chk("t4.i.flush_done", 32'(flush_done), 1);
        chk("t4.i.out_valid", 32'(out_valid), 0);
        chk("t4.i.s1_ready", 32'(s1_ready), 0);
        @(negedge clock);
        #1;
        chk("t4.j.flush_done", 32'(flush_done), 0);
        chk("t4.j.s1_ready_run", 32'(s1_ready), 1);
        @(negedge clock);
        drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        chk("t4.k.out_pc", out_pc, 32'h50c);
        chk("t4.k.flush_done", 32'(flush_done), 0);
        @(negedge clock);

        // Reset with three records buffered.
        for (int k = 0; k < 3; k++) begin
            drv(1'b1, 1'b1, 32'h600 + 32'(4 * k), 1'b0, 32'h0, 1'b0, 1'b0);
            #1;
            chk($sformatf("t5.fill%0d.s0_ready", k), 32'(s0_ready), 1);
            @(negedge clock);
        end
        drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("t5.occupancy_pre", 32'(occupancy), 3);
        chk("t5.out_pc_pre", out_pc, 32'h600);
        reset = 1'b0;
        drv(1'b1, 1'b1, 32'h6ff, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        chk("t5.rst.out_valid", 32'(out_valid), 0);
        chk("t5.rst.occupancy", 32'(occupancy), 0);
        chk("t5.rst.flush_done", 32'(flush_done), 0);
        chk("t5.rst.s0_ready", 32'(s0_ready), 0);
        @(negedge clock);
        reset = 1'b1;
        drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        chk("t5.rel.out_valid", 32'(out_valid), 0);
        chk("t5.rel.flush_done", 32'(flush_done), 0);
        @(negedge clock);
        drv(1'b1, 1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        chk("t5.push.s0_ready", 32'(s0_ready), 1);
        @(negedge clock);
        drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        chk("t5.first.out_valid", 32'(out_valid), 1);
        chk("t5.first.out_pc", out_pc, 32'h700);
        chk("t5.first.occupancy", 32'(occupancy), 1);
        @(negedge clock);

`ifdef COMMIT_TRACE_STAT_EN
        pulse_reset();
        drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            drv(1'b1, 1'b1, 32'h800 + 32'(4 * k), 1'b0, 32'h0, 1'b0, 1'b1);
            @(negedge clock);
        end
        for (int k = 0; k < 3; k++) begin
            drv(1'b1, 1'b0, 32'h0, 1'b1, 32'h900 + 32'(4 * k), 1'b0, 1'b1);
            @(negedge clock);
        end
        drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        chk("t6.stat_s0_cnt", stat_s0_cnt, 5);
        chk("t6.stat_s1_cnt", stat_s1_cnt, 3);
        chk("t6.stat_full_cyc", stat_full_cyc, 0);
        @(negedge clock);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
